snake_step_ctrl: RTL and testbench
==================================

# snake_step_ctrl

Sequences the snake's heading and movement cadence. Buffers one-cycle direction button pulses, rejects reversals and no-op turns, and commits at most one heading change per game step. Generates the periodic `step` pulse consumed by the body/position logic, with a run/pause/dead state machine and food-driven speed-up. Sits between the button debouncers and the snake body datapath, replacing free-running direction updates.

## Interface
- `TICK_DIV`, 2500000: clock cycles per step at reset speed.
- `MIN_DIV`, 500000: lower bound on step period.
- `SPEED_STEP`, 100000: period decrement per `speed_up`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; IDLE→RUN.
- `pause` in 1: one-cycle pulse; toggles RUN↔PAUSE.
- `game_over` in 1: level or pulse; any state except IDLE → DEAD.
- `speed_up` in 1: one-cycle pulse on food eaten.
- `left`, `right`, `up`, `down` in 1 each: one-cycle debounced press pulses.
- `dir` out 2: committed heading; UP=0, LEFT=1, DOWN=2, RIGHT=3.
- `step` out 1: one-cycle move pulse; `dir` is already valid for this move.
- `run_state` out 2: IDLE=0, RUN=1, PAUSE=2, DEAD=3.
- `period` out 32: current step period in cycles.

## Operation
- Reset values: `dir`=RIGHT, `step`=0, `run_state`=IDLE, `period`=`TICK_DIV`, counter=0, queue empty.
- FSM:
  - IDLE→RUN on `start`.
  - RUN→PAUSE and PAUSE→RUN on `pause`.
  - RUN/PAUSE→DEAD on `game_over`; `game_over` has priority over `pause` in the same cycle.
  - DEAD exits only via `rst`.
- Press capture happens in RUN only; presses in IDLE, PAUSE and DEAD are dropped.
  - Simultaneous presses: priority left > right > up > down; one candidate per cycle.
- Filter: the reference heading is the queue tail if the queue is non-empty, else `dir`.
  - Reject a candidate equal to the reference.
  - Reject a candidate that is the reversal of the reference (`cand ^ 2'b10 == ref`).
- Queue: 2-entry FIFO of accepted headings.
  - Push while full is dropped, unless a pop occurs in the same cycle, in which case the push is accepted.
- Step counter: runs only in RUN and holds its value in PAUSE.
  - Wraps when `cnt >= period-1`. At that edge: cnt←0, `step`←1, and if the queue is non-empty, `dir`←head and head is popped.
  - At most one heading change per step.
- Speed-up: accepted in RUN and PAUSE. `period` ← max(`period`−`SPEED_STEP`, `MIN_DIV`), with no underflow. The new value applies to the current count via the `>=` compare.

## Timing
- `step` is registered and high exactly one cycle per period; the period measures edge to edge.
- A press accepted in cycle N with an empty queue appears on `dir` at the next wrap edge, not before.
- `start` in cycle N → `run_state`=RUN in N+1; the first `step` comes `period` cycles after entering RUN.
- `pause` in the wrap cycle: the wrap completes (step fires), then the FSM enters PAUSE.
- `game_over` in the wrap cycle: no step, and the queue is frozen.

## Configuration
- `STEP_CMD_QUEUE_EN` defined: 2-entry FIFO as above.
- Not defined: single pending register.
  - Each accepted press overwrites it, with the filter reference always `dir`.
  - It is consumed at the wrap, so the latest valid press wins.

## Structure
- Shared package `snake_pkg` holds:
  - direction encodings `DIR_UP`/`DIR_LEFT`/`DIR_DOWN`/`DIR_RIGHT`;
  - run-state encodings;
  - a reversal helper function.
- Sub-module `step_timer` contains the counter, period register, saturating speed-up and `step` generation, with `enable`/`hold` from the FSM. Queue, filter and FSM stay in the top.

## Test plan
Bench parameters: `TICK_DIV`=8, `MIN_DIV`=4, `SPEED_STEP`=3.
- Reset, `start`, no presses → `dir` stays 3; `step` high every 8 cycles, first pulse 8 cycles after RUN.
- `dir`=RIGHT, press `left` → rejected (reversal); press `up` → `dir`=0 at the next step, not earlier.
- RUN, press `up` then `left` within one period → `dir`=0 at step k, `dir`=1 at step k+1. A third press while full is dropped when the queue is enabled. Without the macro, `dir`=1 at step k.
- `speed_up` ×2 → `period` 8→5→4 (saturates); step spacing becomes 4.
- `pause` mid-count at cnt=3, wait 20 cycles, `pause` → the next step arrives 5 cycles later. Presses while paused do not change `dir`.
- `game_over` in the wrap cycle → no step, `run_state`=3, `dir` frozen; `rst` → `dir`=3, IDLE, `period`=8.

Source files
------------

// File: rtl/snake_pkg.sv
// =============================================================================
// Module  : snake_pkg
// Brief   : Heading and run-state encodings shared by the snake step control.
// Revision: 1.0
// =============================================================================
`default_nettype none

package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DEAD  = 2'd3;

    // Opposite headings differ only in the upper encoding bit.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_step_ctrl_step_timer.sv
// =============================================================================
// Module  : step_timer
// Brief   : Step period counter with saturating speed-up and registered step.
// Revision: 1.0
// =============================================================================
`default_nettype none

module step_timer #(
    parameter int unsigned TICK_DIV   = 2500000,
    parameter int unsigned MIN_DIV    = 500000,
    parameter int unsigned SPEED_STEP = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        hold,
    input  logic        speed_up,
    output logic        step,
    output logic        wrap,
    output logic [31:0] period
);

    localparam logic [31:0] c_TICK  = 32'(TICK_DIV);
    localparam logic [31:0] c_MIN   = 32'(MIN_DIV);
    localparam logic [31:0] c_SPEED = 32'(SPEED_STEP);
    localparam logic [31:0] c_FLOOR = c_MIN + c_SPEED;

    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic        r_step;
    logic        w_wrap;

    assign w_wrap = enable && !hold && (r_cnt >= r_period - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 32'd0;
            r_period <= c_TICK;
            r_step   <= 1'b0;
        end else begin
            r_step <= w_wrap;
            if (enable && !hold) begin
                r_cnt <= w_wrap ? 32'd0 : r_cnt + 32'd1;
            end
            // Compare against the floor first so the subtraction never wraps.
            if (enable && speed_up) begin
                r_period <= (r_period >= c_FLOOR) ? r_period - c_SPEED : c_MIN;
            end
        end
    end

    assign step   = r_step;
    assign wrap   = w_wrap;
    assign period = r_period;

endmodule

`default_nettype wire

// File: rtl/snake_step_ctrl.sv
// =============================================================================
// Module  : snake_step_ctrl
// Brief   : Heading filter/queue, run FSM and step cadence for the snake.
//           STEP_CMD_QUEUE_EN selects a 2-entry heading FIFO over one pending slot.
// Revision: 1.0
// =============================================================================
`default_nettype none

module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 2500000,
    parameter int unsigned MIN_DIV    = 500000,
    parameter int unsigned SPEED_STEP = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        speed_up,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    output logic [1:0]  dir,
    output logic        step,
    output logic [1:0]  run_state,
    output logic [31:0] period
);

    logic [1:0] r_state;
    logic [1:0] r_dir;
    logic       w_wrap;
    logic       w_capture;
    logic       w_cand_v;
    logic [1:0] w_cand;
    logic [1:0] w_ref;
    logic       w_accept;
    logic       w_next_v;
    logic [1:0] w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (start) r_state <= c_ST_RUN;
                c_ST_RUN:   if (game_over) r_state <= c_ST_DEAD;
                            else if (pause) r_state <= c_ST_PAUSE;
                c_ST_PAUSE: if (game_over) r_state <= c_ST_DEAD;
                            else if (pause) r_state <= c_ST_RUN;
                default:    r_state <= c_ST_DEAD;
            endcase
        end
    end

    step_timer #(
        .TICK_DIV  (TICK_DIV),
        .MIN_DIV   (MIN_DIV),
        .SPEED_STEP(SPEED_STEP)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  ((r_state == c_ST_RUN) || (r_state == c_ST_PAUSE)),
        .hold    ((r_state != c_ST_RUN) || game_over),
        .speed_up(speed_up),
        .step    (step),
        .wrap    (w_wrap),
        .period  (period)
    );

    // A game_over cycle freezes capture as well as the step.
    assign w_capture = (r_state == c_ST_RUN) && !game_over;

    always_comb begin
        w_cand_v = left | right | up | down;
        if (left)       w_cand = DIR_LEFT;
        else if (right) w_cand = DIR_RIGHT;
        else if (up)    w_cand = DIR_UP;
        else            w_cand = DIR_DOWN;
    end

    assign w_accept = w_capture && w_cand_v && (w_cand != w_ref) &&
                      (w_cand != dir_reverse(w_ref));

`ifdef STEP_CMD_QUEUE_EN
    logic [1:0] r_q0;
    logic [1:0] r_q1;
    logic [1:0] r_qcnt;
    logic       w_pop;
    logic       w_push;

    assign w_ref  = (r_qcnt == 2'd2) ? r_q1 : (r_qcnt == 2'd1) ? r_q0 : r_dir;
    assign w_pop  = w_wrap && (r_qcnt != 2'd0);
    assign w_push = w_accept && ((r_qcnt != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q0   <= DIR_RIGHT;
            r_q1   <= DIR_RIGHT;
            r_qcnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_qcnt == 2'd1) begin
                        r_q0 <= w_cand;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= w_cand;
                    end
                end
                2'b01: begin
                    r_q0   <= r_q1;
                    r_qcnt <= r_qcnt - 2'd1;
                end
                2'b10: begin
                    if (r_qcnt == 2'd0) r_q0 <= w_cand;
                    else                r_q1 <= w_cand;
                    r_qcnt <= r_qcnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_next_v = w_pop;
    assign w_next   = r_q0;
`else
    logic [1:0] r_pend;
    logic       r_pend_v;

    assign w_ref = r_dir;
    // A press taken in a wrap cycle was filtered against the outgoing heading,
    // so it is re-checked against the heading it will actually replace.
    assign w_next_v = w_wrap && r_pend_v && (r_pend != r_dir) &&
                      (r_pend != dir_reverse(r_dir));
    assign w_next   = r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= DIR_RIGHT;
            r_pend_v <= 1'b0;
        end else if (w_accept) begin
            r_pend   <= w_cand;
            r_pend_v <= 1'b1;
        end else if (w_wrap) begin
            r_pend_v <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= DIR_RIGHT;
        end else if (w_next_v) begin
            r_dir <= w_next;
        end
    end

    assign dir       = r_dir;
    assign run_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
// =============================================================================
// Module  : tb_snake_step_ctrl
// Brief   : Directed bench for snake_step_ctrl (TICK_DIV=8, MIN_DIV=4, SPEED_STEP=3).
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_snake_step_ctrl;
    import snake_pkg::*;

`ifdef STEP_CMD_QUEUE_EN
    localparam logic [1:0] c_EXP_K  = DIR_LEFT;
    localparam logic [1:0] c_EXP_K1 = DIR_DOWN;
`else
    localparam logic [1:0] c_EXP_K  = DIR_RIGHT;
    localparam logic [1:0] c_EXP_K1 = DIR_RIGHT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, game_over = 1'b0, speed_up = 1'b0;
    logic        left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic [1:0]  dir;
    logic        step;
    logic [1:0]  run_state;
    logic [31:0] period;

    int n_checks = 0;
    int n_errors = 0;
    int n_wait;
    int n_steps;

    always #5 clk = ~clk;

    snake_step_ctrl #(
        .TICK_DIV  (8),
        .MIN_DIV   (4),
        .SPEED_STEP(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .game_over(game_over),
        .speed_up (speed_up),
        .left     (left),
        .right    (right),
        .up       (up),
        .down     (down),
        .dir      (dir),
        .step     (step),
        .run_state(run_state),
        .period   (period)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until step is seen high; gives up after 64 so a dead DUT still ends.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (step !== 1'b1 && n < 64);
    endtask

    initial begin
        // Reset state
        cyc(2);
        rst = 1'b0;
        check_val("rst_dir", 32'(dir), 32'(DIR_RIGHT));
        check_val("rst_step", 32'(step), 32'd0);
        check_val("rst_state", 32'(run_state), 32'(c_ST_IDLE));
        check_val("rst_period", period, 32'd8);

        // Press in IDLE is dropped; start enters RUN next cycle
        up = 1'b1; cyc(1); up = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        check_val("start_run", 32'(run_state), 32'(c_ST_RUN));
        wait_step(n_wait);
        check_val("first_step_gap", 32'(n_wait), 32'd8);
        check_val("idle_press_dropped", 32'(dir), 32'(DIR_RIGHT));
        cyc(1);
        check_val("step_one_cycle", 32'(step), 32'd0);
        wait_step(n_wait);
        check_val("step_period", 32'(n_wait), 32'd7);

        // Reversal rejected; valid turn lands only on the next step
        left = 1'b1; cyc(1); left = 1'b0;
        up = 1'b1; cyc(1); up = 1'b0;
        check_val("turn_not_early", 32'(dir), 32'(DIR_RIGHT));
        wait_step(n_wait);
        check_val("turn_gap", 32'(n_wait), 32'd6);
        check_val("turn_up", 32'(dir), 32'(DIR_UP));

        // Three presses in one period: left, down, right
        left = 1'b1;  cyc(1); left = 1'b0;
        down = 1'b1;  cyc(1); down = 1'b0;
        right = 1'b1; cyc(1); right = 1'b0;
        wait_step(n_wait);
        check_val("multi_step_k", 32'(dir), 32'(c_EXP_K));
        wait_step(n_wait);
        check_val("multi_step_k1", 32'(dir), 32'(c_EXP_K1));

        // Pause at cnt=3, 20 paused cycles with presses, resume
        cyc(3);
        pause = 1'b1; cyc(1); pause = 1'b0;
        check_val("pause_state", 32'(run_state), 32'(c_ST_PAUSE));
        n_steps = 0;
        for (int i = 0; i < 20; i++) begin
            up   = (i == 2);
            left = (i == 5);
            cyc(1);
            if (step) n_steps++;
        end
        up = 1'b0; left = 1'b0;
        check_val("pause_no_step", 32'(n_steps), 32'd0);
        pause = 1'b1; cyc(1); pause = 1'b0;
        check_val("resume_state", 32'(run_state), 32'(c_ST_RUN));
        wait_step(n_wait);
        check_val("resume_gap", 32'(n_wait), 32'd4);
        check_val("pause_press_dropped", 32'(dir), 32'(c_EXP_K1));

        // Speed-up saturates at MIN_DIV; shorter period hits the running count
        speed_up = 1'b1;
        cyc(1); check_val("speed_1", period, 32'd5);
        cyc(1); check_val("speed_2", period, 32'd4);
        cyc(1); check_val("speed_sat", period, 32'd4);
        speed_up = 1'b0;
        wait_step(n_wait);
        check_val("speed_immediate", 32'(n_wait), 32'd1);
        wait_step(n_wait);
        check_val("fast_gap_a", 32'(n_wait), 32'd4);
        wait_step(n_wait);
        check_val("fast_gap_b", 32'(n_wait), 32'd4);

        // game_over in the wrap cycle with a pending turn
        left = 1'b1; cyc(1); left = 1'b0;
        up = 1'b1;   cyc(1); up = 1'b0;
        cyc(1);
        game_over = 1'b1; cyc(1); game_over = 1'b0;
        check_val("dead_no_step", 32'(step), 32'd0);
        check_val("dead_state", 32'(run_state), 32'(c_ST_DEAD));
        n_steps = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 1);
            pause = (i == 3);
            cyc(1);
            if (step) n_steps++;
        end
        start = 1'b0; pause = 1'b0;
        check_val("dead_no_steps", 32'(n_steps), 32'd0);
        check_val("dead_sticky", 32'(run_state), 32'(c_ST_DEAD));
        check_val("dead_dir_frozen", 32'(dir), 32'(c_EXP_K1));

        rst = 1'b1; cyc(1); rst = 1'b0;
        check_val("rerst_dir", 32'(dir), 32'(DIR_RIGHT));
        check_val("rerst_state", 32'(run_state), 32'(c_ST_IDLE));
        check_val("rerst_period", period, 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
